serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: start  input  1  request to begin a subtraction; honoured only in IDLE.
REQ-005: a  input  WIDTH  minuend; captured on the edge that accepts start.
REQ-006: b  input  WIDTH  subtrahend; captured on the edge that accepts start.
REQ-007: busy  output  1  high in RUN and DONE, low in IDLE.
REQ-008: done  output  1  one-cycle pulse marking diff/borrow_out valid.
REQ-009: diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010: borrow_out  output  1  high when a < b (unsigned).

Function
REQ-011: The FSM SHALL have exactly three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-012: In IDLE with start=1, the block SHALL capture a and b into internal shift registers, clear the borrow flop and the bit counter, and move to RUN.
REQ-013: In IDLE with start=0, the FSM SHALL remain in IDLE and hold diff and borrow_out unchanged.
REQ-014: In RUN, each edge SHALL process one bit, LSB first: d = a_i XOR b_i XOR bw; bw_next = (~a_i & b_i) | (~(a_i XOR b_i) & bw), i.e. two cascaded half-subtractor stages.
REQ-015: The result bit SHALL shift into diff from the MSB side, so diff holds the full result after WIDTH bit-edges.
REQ-016: The bit counter SHALL count 0..WIDTH-1; the edge that processes bit WIDTH-1 SHALL move the FSM to RUN->DONE and load borrow_out with the final bw_next.
REQ-017: Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH) and low after edge E(WIDTH+1).
REQ-018: DONE SHALL last exactly one cycle and then move unconditionally to IDLE.
REQ-019: Start in RUN or DONE SHALL be ignored, with no queueing and no effect on operands or count.
REQ-020: Start in the first IDLE cycle after DONE SHALL be accepted normally, giving a back-to-back period of WIDTH+2 cycles.
REQ-021: Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-022: diff and borrow_out SHALL hold their last result from DONE until the next accepted start.
REQ-023: During RUN, diff and borrow_out are undefined and SHALL NOT be interpreted by consumers.
REQ-024: The combination borrow_out=1 with diff=0 SHALL never occur.

Reset
REQ-025: With rst=1 at an edge, the block SHALL set state=IDLE, busy=0, done=0, diff=0, borrow_out=0, and clear the counter and internal borrow.
REQ-026: rst SHALL take priority over start in every state.
REQ-027: Reset mid-RUN SHALL abandon the operation with no done pulse.
REQ-028: Reset during DONE SHALL truncate the done pulse to that cycle.
REQ-029: After rst deasserts, a start on the first edge SHALL be accepted.

Verification
REQ-030: WIDTH=8, a=0x05, b=0x03, start pulse -> done 8 cycles after acceptance; diff=0x02, borrow_out=0.
REQ-031: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; and a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-032: a=0x00, b=0x00 and a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
REQ-033: Start with a=0x10, b=0x01, then a second start with a=0x00, b=0x01 at RUN bit 3, with a/b toggled during RUN -> single done pulse; diff=0x0F, borrow_out=0.
REQ-034: rst asserted at RUN bit 4 -> no done pulse; after reset busy=0, diff=0x00, borrow_out=0; a next start of 0x80-0x01 -> diff=0x7F.
REQ-035: Back-to-back starts held high continuously -> one done every 10 cycles (WIDTH+2) with a correct result each time, checked against a reference model over 1000 random operand pairs.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
// Produces diff = a - b (mod 2^WIDTH) and borrow_out = (a < b) after WIDTH bit-edges.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bw;
   logic [CW-1:0]    r_cnt;

   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_bw_next;
   logic             w_last;
   logic [WIDTH-1:0] w_shift;

   // Two cascaded half-subtractors: a_i - b_i, then minus the incoming borrow.
   assign w_ai      = r_a[0];
   assign w_bi      = r_b[0];
   assign w_d       = w_ai ^ w_bi ^ r_bw;
   assign w_bw_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bw);
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign w_shift   = {w_d, r_res};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Partial result is kept apart from diff so the published result stays stable during RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bw     <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_bw  <= 1'b0;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_bw  <= w_bw_next;
               r_res <= w_shift[WIDTH-1:1];
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_diff   <= w_shift;
                  r_borrow <= w_bw_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;

endmodule
